// File: rtl/csr_bank_pkg.sv
// rtl/csr_bank_pkg.sv - shared word map, FSM states, status layout and lane merge for soc_csr_bank
package csr_bank_pkg;

  localparam int ADDR_ID       = 0;
  localparam int ADDR_IRQ_STAT = 1;
  localparam int ADDR_IRQ_EN   = 2;
  localparam int ADDR_SCRATCH  = 3;
  localparam int ADDR_CH_BASE  = 4;

  localparam int ERR_BIT = 15;

  typedef enum logic {
    IDLE,
    ACK
  } state_t;

  typedef struct packed {
    logic        busy;
    logic        ovf;
    logic [5:0]  rsvd;
    logic [23:0] cnt;
  } ch_stat_t;

  // Replace only the byte lanes whose enable is set.
  function automatic logic [31:0] lane_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  be);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = be[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/csr_bank_irq.sv
// rtl/csr_bank_irq.sv - event edge capture, W1C interrupt status and masked irq output
module csr_bank_irq
  import csr_bank_pkg::*;
#(
  parameter int NUM_CH = 4
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic [NUM_CH-1:0] ch_evt,
  input  logic              err_set,
  input  logic              w1c_en,
  input  logic [31:0]       w1c_mask,
  input  logic [31:0]       irq_en,
  output logic [31:0]       irq_stat,
  output logic              irq
);

  localparam logic [31:0] VALID = (32'h1 << ERR_BIT) | ((32'h1 << NUM_CH) - 32'h1);

  logic [NUM_CH-1:0] evt_q;
  logic [31:0]       stat_q;
  logic [31:0]       set_vec;
  logic [31:0]       clr_vec;

  // Rising edges and bus errors form the set vector; W1C forms the clear vector.
  always_comb begin
    set_vec              = '0;
    set_vec[NUM_CH-1:0]  = ch_evt & ~evt_q;
    set_vec[ERR_BIT]     = err_set;
    clr_vec              = w1c_en ? w1c_mask : '0;
  end

  // Status register: clear first, then set, so a coincident set wins.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      evt_q  <= '0;
      stat_q <= '0;
    end else begin
      evt_q  <= ch_evt;
      stat_q <= ((stat_q & ~clr_vec) | set_vec) & VALID;
    end
  end

  assign irq_stat = stat_q;
  assign irq      = |(stat_q & irq_en);

endmodule

// File: rtl/soc_csr_bank.sv
// rtl/soc_csr_bank.sv - parametrised CSR bank with per-channel CTRL/STAT, scratch and interrupts
module soc_csr_bank
  import csr_bank_pkg::*;
#(
  parameter int          NUM_CH    = 4,
  parameter int          AW        = 12,
  parameter int          CNT_W     = 16,
  parameter logic [31:0] CTRL_INIT = 32'h0,
  parameter logic [31:0] VERSION   = 32'h0002_0000
) (
  input  logic                    clk,
  input  logic                    arst_n,
  input  logic                    bus_vld,
  input  logic [3:0]              bus_we,
  input  logic [AW-3:0]           bus_addr,
  input  logic [31:0]             bus_wdat,
  output logic [31:0]             bus_rdat,
  output logic                    bus_rdy,
  output logic [NUM_CH*32-1:0]    ch_ctrl,
  output logic [NUM_CH-1:0]       ch_ctrl_wr,
  input  logic [NUM_CH-1:0]       ch_busy,
  input  logic [NUM_CH*CNT_W-1:0] ch_cnt,
  input  logic [NUM_CH-1:0]       ch_evt,
  input  logic [NUM_CH-1:0]       ch_ovf,
  output logic                    irq
);

  localparam logic [31:0] EN_MASK = (32'h1 << ERR_BIT) | ((32'h1 << NUM_CH) - 32'h1);

  if (NUM_CH < 1 || NUM_CH > 15 || CNT_W < 1 || CNT_W > 24 ||
      (ADDR_CH_BASE + 2 * NUM_CH) > (1 << (AW - 2))) begin : g_param_err
    $error("soc_csr_bank: illegal NUM_CH/CNT_W/AW combination");
  end

  state_t                state_q, state_d;
  logic [31:0]           rdat_q;
  logic [31:0]           addr_w;
  logic                  is_wr, commit, hit;
  logic                  id_hit, istat_hit, en_hit, scr_hit;
  logic [NUM_CH-1:0]     ctrl_hit, chst_hit;
  logic [31:0]           rd_data;
  ch_stat_t              stat_v;
  logic [31:0]           irq_en_q, scratch_q, irq_stat;
  logic [NUM_CH*32-1:0]  ch_ctrl_q;
  logic [NUM_CH-1:0]     ch_ctrl_wr_q, ovf_q;

  assign addr_w = 32'(bus_addr);
  assign is_wr  = |bus_we;
  assign commit = (state_q == ACK) && bus_vld;

  // Handshake next state: one ACK cycle per accepted request.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus_vld) state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Address decode and read mux.
  always_comb begin
    id_hit    = (addr_w == 32'(ADDR_ID));
    istat_hit = (addr_w == 32'(ADDR_IRQ_STAT));
    en_hit    = (addr_w == 32'(ADDR_IRQ_EN));
    scr_hit   = (addr_w == 32'(ADDR_SCRATCH));
    ctrl_hit  = '0;
    chst_hit  = '0;
    rd_data   = '0;
    stat_v    = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      ctrl_hit[n] = (addr_w == 32'(ADDR_CH_BASE + 2 * n));
      chst_hit[n] = (addr_w == 32'(ADDR_CH_BASE + 2 * n + 1));
    end
    hit = id_hit | istat_hit | en_hit | scr_hit | (|ctrl_hit) | (|chst_hit);
    if (id_hit)    rd_data = VERSION;
    if (istat_hit) rd_data = irq_stat;
    if (en_hit)    rd_data = irq_en_q;
    if (scr_hit)   rd_data = scratch_q;
    for (int n = 0; n < NUM_CH; n++) begin
      if (ctrl_hit[n]) rd_data = ch_ctrl_q[32*n +: 32];
      if (chst_hit[n]) begin
        stat_v.busy = ch_busy[n];
        stat_v.ovf  = ovf_q[n];
        stat_v.cnt  = 24'(ch_cnt[n*CNT_W +: CNT_W]);
        rd_data     = stat_v;
      end
    end
  end

  // FSM state and read-data capture; rdat is nonzero only while in ACK.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= IDLE;
      rdat_q  <= '0;
    end else begin
      state_q <= state_d;
      rdat_q  <= (state_q == IDLE && bus_vld && !is_wr) ? rd_data : 32'h0;
    end
  end

  // Writable registers commit at the end of ACK, lane-masked; busy channels ignore CTRL writes.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      irq_en_q     <= '0;
      scratch_q    <= '0;
      ch_ctrl_q    <= {NUM_CH{CTRL_INIT}};
      ch_ctrl_wr_q <= '0;
    end else begin
      ch_ctrl_wr_q <= (commit && is_wr) ? (ctrl_hit & ~ch_busy) : '0;
      if (commit && is_wr && en_hit)  irq_en_q  <= lane_merge(irq_en_q, bus_wdat, bus_we) & EN_MASK;
      if (commit && is_wr && scr_hit) scratch_q <= lane_merge(scratch_q, bus_wdat, bus_we);
      for (int n = 0; n < NUM_CH; n++) begin
        if (commit && is_wr && ctrl_hit[n] && !ch_busy[n])
          ch_ctrl_q[32*n +: 32] <= lane_merge(ch_ctrl_q[32*n +: 32], bus_wdat, bus_we);
      end
    end
  end

  // Sticky overflow: cleared by a committed STAT read, a coincident pulse re-sets it.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) ovf_q <= '0;
    else         ovf_q <= (ovf_q & ~((commit && !is_wr) ? chst_hit : '0)) | ch_ovf;
  end

  csr_bank_irq #(.NUM_CH(NUM_CH)) u_irq (
    .clk      (clk),
    .arst_n   (arst_n),
    .ch_evt   (ch_evt),
    .err_set  (commit && !hit),
    .w1c_en   (commit && is_wr && istat_hit),
    .w1c_mask (lane_merge(32'h0, bus_wdat, bus_we)),
    .irq_en   (irq_en_q),
    .irq_stat (irq_stat),
    .irq      (irq)
  );

  assign bus_rdy    = (state_q == ACK);
  assign bus_rdat   = rdat_q;
  assign ch_ctrl    = ch_ctrl_q;
  assign ch_ctrl_wr = ch_ctrl_wr_q;

endmodule

// File: tb/tb_soc_csr_bank.sv
// tb/tb_soc_csr_bank.sv - scoreboard bench for soc_csr_bank against a word-map reference model
module tb_soc_csr_bank;

  localparam int          NUM_CH = 4;
  localparam int          CNT_W  = 16;
  localparam logic [31:0] VER    = 32'h0002_0000;
  localparam logic [31:0] VALID  = 32'h0000_800F;

  logic              clk = 1'b0;
  logic              arst_n;
  logic              bus_vld;
  logic [3:0]        bus_we;
  logic [9:0]        bus_addr;
  logic [31:0]       bus_wdat;
  logic [31:0]       bus_rdat;
  logic              bus_rdy;
  logic [127:0]      ch_ctrl;
  logic [3:0]        ch_ctrl_wr;
  logic [3:0]        ch_busy;
  logic [63:0]       ch_cnt;
  logic [3:0]        ch_evt;
  logic [3:0]        ch_ovf;
  logic              irq;

  always #5 clk = ~clk;

  soc_csr_bank #(.NUM_CH(NUM_CH), .AW(12), .CNT_W(CNT_W)) dut (
    .clk(clk), .arst_n(arst_n), .bus_vld(bus_vld), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdat(bus_wdat), .bus_rdat(bus_rdat), .bus_rdy(bus_rdy),
    .ch_ctrl(ch_ctrl), .ch_ctrl_wr(ch_ctrl_wr), .ch_busy(ch_busy), .ch_cnt(ch_cnt),
    .ch_evt(ch_evt), .ch_ovf(ch_ovf), .irq(irq)
  );

  typedef struct {
    bit          chk;
    logic [31:0] exp;
    logic [9:0]  addr;
  } exp_t;
  exp_t sbq[$];

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [31:0] m_scr, m_en, m_stat;
  logic [31:0] m_ctrl[NUM_CH];
  logic [3:0]  m_ovf;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_scr = 0; m_en = 0; m_stat = 0; m_ovf = 0;
    for (int n = 0; n < NUM_CH; n++) m_ctrl[n] = 32'h0;
  endtask

  function automatic logic [31:0] bytes_sel(input logic [31:0] old_v, input logic [31:0] new_v,
                                            input logic [3:0] be);
    logic [31:0] m;
    m = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    return (old_v & ~m) | (new_v & m);
  endfunction

  function automatic logic [31:0] model_read(input logic [9:0] a);
    int n;
    if (a == 0) return VER;
    if (a == 1) return m_stat;
    if (a == 2) return m_en;
    if (a == 3) return m_scr;
    if (a >= 4 && a < 4 + 2 * NUM_CH) begin
      n = (int'(a) - 4) / 2;
      if (a[0] == 1'b0) return m_ctrl[n];
      return {ch_busy[n], m_ovf[n], 14'h0, ch_cnt[n*CNT_W +: CNT_W]};
    end
    return 32'h0;
  endfunction

  // One bus access; evt_mask raises ch_evt bits during ACK so the edge lands on the commit edge.
  task automatic acc(input logic [3:0] we, input logic [9:0] a, input logic [31:0] wdat,
                     input logic [3:0] evt_mask, output logic [31:0] got);
    int          cyc;
    int          n;
    exp_t        e;
    logic [31:0] clr, set;
    logic [3:0]  exp_pulse;
    @(posedge clk); #1;
    bus_vld = 1'b1; bus_we = we; bus_addr = a; bus_wdat = wdat;
    e.chk = (we == 4'h0); e.exp = model_read(a); e.addr = a;
    sbq.push_back(e);
    cyc = 0;
    do begin
      @(posedge clk); #1; cyc++;
    end while (!bus_rdy && cyc < 8);
    check("rdy_latency", 32'(cyc), 32'd1);
    if (!bus_rdy) void'(sbq.pop_back());
    got = bus_rdat;
    ch_evt = ch_evt | evt_mask;
    @(posedge clk); #1;
    bus_vld = 1'b0; bus_we = 4'h0;
    // model commit
    exp_pulse = 4'h0;
    clr = 32'h0;
    n = (int'(a) - 4) / 2;
    if (we != 4'h0) begin
      if (a == 1) clr = bytes_sel(32'h0, wdat, we);
      if (a == 2) m_en = bytes_sel(m_en, wdat, we) & VALID;
      if (a == 3) m_scr = bytes_sel(m_scr, wdat, we);
      if (a >= 4 && a < 4 + 2 * NUM_CH && a[0] == 1'b0 && !ch_busy[n]) begin
        m_ctrl[n] = bytes_sel(m_ctrl[n], wdat, we);
        exp_pulse[n] = 1'b1;
      end
    end else if (a >= 4 && a < 4 + 2 * NUM_CH && a[0] == 1'b1) begin
      m_ovf[n] = 1'b0;
    end
    set = {28'h0, evt_mask};
    if (a >= 4 + 2 * NUM_CH) set[15] = 1'b1;
    m_stat = ((m_stat & ~clr) | set) & VALID;
    check("ctrl_wr_pulse", 32'(ch_ctrl_wr), 32'(exp_pulse));
    check("irq", 32'(irq), 32'(|(m_stat & m_en)));
  endtask

  // monitor: pops one expectation per completed access
  always @(negedge clk) begin
    if (arst_n && bus_rdy) begin
      if (sbq.size() == 0) begin
        total++; bad++;
        $display("FAIL sb_unexpected: rdy with rdat %h, want no access pending", bus_rdat);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        if (e.chk) check($sformatf("rdat@%0h", e.addr), bus_rdat, e.exp);
      end
    end
  end

  initial begin
    logic [31:0] got;
    int          kind, ch, cyc;
    logic [9:0]  a;
    arst_n = 1'b0; bus_vld = 0; bus_we = 0; bus_addr = 0; bus_wdat = 0;
    ch_busy = 0; ch_cnt = 0; ch_evt = 0; ch_ovf = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 arst_n = 1'b1;
    @(negedge clk);
    check("rst_rdy", 32'(bus_rdy), 32'h0);
    check("rst_rdat", bus_rdat, 32'h0);
    for (int n = 0; n < NUM_CH; n++) check("rst_ctrl", ch_ctrl[32*n +: 32], 32'h0);
    check("rst_ctrl_wr", 32'(ch_ctrl_wr), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);

    acc(4'h0, 10'd0, 32'h0, 4'h0, got);
    check("id", got, 32'h0002_0000);

    acc(4'b0101, 10'd3, 32'hDEAD_BEEF, 4'h0, got);
    acc(4'h0, 10'd3, 32'h0, 4'h0, got);
    check("scratch_lanes", got, 32'h00AD_00EF);

    ch_busy = 4'b0100;
    acc(4'hF, 10'd8, 32'h1234, 4'h0, got);
    check("busy_ctrl", ch_ctrl[95:64], 32'h0);
    ch_busy = 4'b0000;
    acc(4'hF, 10'd8, 32'h1234, 4'h0, got);
    check("ctrl2", ch_ctrl[95:64], 32'h1234);
    check("ctrl_wr_on", 32'(ch_ctrl_wr), 32'h4);
    @(posedge clk); #1;
    check("ctrl_wr_off", 32'(ch_ctrl_wr), 32'h0);

    acc(4'hF, 10'd2, 32'h2, 4'h0, got);
    @(posedge clk); #1 ch_evt[1] = 1'b1;
    m_stat[1] = 1'b1;
    repeat (2) @(posedge clk);
    #1 check("evt_irq", 32'(irq), 32'h1);
    ch_evt[1] = 1'b0;
    repeat (2) @(posedge clk);
    acc(4'hF, 10'd1, 32'h2, 4'b0010, got);
    check("set_wins_irq", 32'(irq), 32'h1);
    acc(4'hF, 10'd1, 32'h2, 4'h0, got);
    check("w1c_irq", 32'(irq), 32'h0);

    ch_cnt[15:0] = 16'hABCD;
    @(posedge clk); #1 ch_ovf[0] = 1'b1;
    @(posedge clk); #1 ch_ovf[0] = 1'b0;
    m_ovf[0] = 1'b1;
    acc(4'h0, 10'd5, 32'h0, 4'h0, got);
    check("ovf_sticky", 32'(got[30]), 32'h1);
    check("cnt_field", 32'(got[15:0]), 32'hABCD);
    acc(4'h0, 10'd5, 32'h0, 4'h0, got);
    check("ovf_cleared", 32'(got[30]), 32'h0);

    acc(4'h0, 10'h3FF, 32'h0, 4'h0, got);
    check("unmapped_rd", got, 32'h0);
    acc(4'h0, 10'd1, 32'h0, 4'h0, got);
    check("err_bit", 32'(got[15]), 32'h1);

    // randomized traffic against the model (event inputs held steady)
    for (int i = 0; i < 300; i++) begin
      ch_busy = 4'($urandom);
      ch_cnt  = {$urandom, $urandom};
      kind = $urandom_range(0, 6);
      ch   = $urandom_range(0, NUM_CH - 1);
      case (kind)
        0, 1, 2, 3: a = 10'(kind);
        4:          a = 10'(4 + 2 * ch);
        5:          a = 10'(5 + 2 * ch);
        default:    a = 10'($urandom_range(4 + 2 * NUM_CH, 1023));
      endcase
      acc(($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom), a, $urandom, 4'h0, got);
    end

    // reset during ACK of a SCRATCH write aborts it
    ch_evt = 4'h0;
    ch_busy = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    bus_vld = 1'b1; bus_we = 4'hF; bus_addr = 10'd3; bus_wdat = 32'h55AA_55AA;
    begin
      exp_t e;
      e.chk = 1'b0; e.exp = 32'h0; e.addr = 10'd3;
      sbq.push_back(e);
    end
    cyc = 0;
    do begin
      @(posedge clk); #1; cyc++;
    end while (!bus_rdy && cyc < 8);
    check("abort_rdy", 32'(bus_rdy), 32'h1);
    if (!bus_rdy) void'(sbq.pop_back());
    @(negedge clk); #1;
    arst_n = 1'b0; bus_vld = 1'b0; bus_we = 4'h0;
    model_reset();
    @(posedge clk); #1;
    check("abort_fsm_idle", 32'(bus_rdy), 32'h0);
    arst_n = 1'b1;
    acc(4'h0, 10'd3, 32'h0, 4'h0, got);
    check("abort_scratch", got, 32'h0);

    repeat (3) @(posedge clk);
    check("sb_drain", 32'(sbq.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/soc_csr_bank.md
Name: soc_csr_bank

Overview:
Parametrised successor of the single-purpose SOC CSR block. It provides NUM_CH identical channel register pairs (CTRL/STAT), a global ID, a scratch register, and an interrupt status/enable pair. Unlike its predecessor, it honours byte enables, uses a registered one-wait-state handshake, supports W1C interrupt status with edge capture, and keeps sticky per-channel overflow flags that clear on read. It sits on the SOC bus as a slave and fans out to per-channel peripherals (DAC/ADC/UART-class engines).

Parameters:
NUM_CH, 4, number of channels; legal range 1..15.
AW, 12, byte address width; word index is bus_addr[AW-1:2].
CNT_W, 16, width of each channel status counter; legal range 1..24.
CTRL_INIT, 32'h0, reset value of every CH_CTRL register.
VERSION, 32'h0002_0000, value returned by ID.

Ports:
clk  in  1  bus clock; sole clock of the block
arst_n  in  1  asynchronous active-low reset
bus_vld  in  1  access request; held high until bus_rdy
bus_we  in  4  byte write enables; any bit set makes the access a write
bus_addr  in  AW-2  word address
bus_wdat  in  32  write data
bus_rdat  out  32  read data; valid when bus_rdy=1
bus_rdy  out  1  access complete
ch_ctrl  out  NUM_CH*32  CTRL register contents, channel n at [32n+31:32n]
ch_ctrl_wr  out  NUM_CH  one-cycle pulse on an accepted CTRL write
ch_busy  in  NUM_CH  channel busy
ch_cnt  in  NUM_CH*CNT_W  channel counters
ch_evt  in  NUM_CH  event level; rising edge raises an interrupt
ch_ovf  in  NUM_CH  overflow pulse; latched as a sticky flag
irq  out  1  level interrupt = |(IRQ_STAT & IRQ_EN)

Behaviour:
- Word map: 0 ID (RO = VERSION); 1 IRQ_STAT (W1C; bit n = ch n event, bit 15 = bus error); 2 IRQ_EN (RW, bits [NUM_CH-1:0] and 15); 3 SCRATCH (RW); 4+2n CH_CTRL[n] (RW); 5+2n CH_STAT[n] (RO: [31]=busy, [30]=ovf sticky, [CNT_W-1:0]=cnt).
- Unmapped address: reads return 0; writes are dropped; IRQ_STAT[15] is set in both cases.
- Handshake FSM has two states, IDLE and ACK. In IDLE with bus_vld=1 → ACK; bus_rdy=1 for exactly one cycle in ACK; then → IDLE. Back-to-back accesses therefore take 2 cycles each.
- Read data is captured on the IDLE→ACK edge and held in ACK. bus_rdat=0 outside ACK.
- Write side effects are committed on the ACK edge (bus_vld & bus_rdy).
- Byte enables: only the lanes with bus_we[i]=1 update SCRATCH, IRQ_EN and CH_CTRL. IRQ_STAT W1C is also lane-masked.
- A CH_CTRL write while ch_busy[n]=1 is ignored entirely: no update, no ch_ctrl_wr pulse. Otherwise ch_ctrl_wr[n]=1 in the cycle after commit, for 1 cycle.
- Event capture: registered previous value of ch_evt; rising edge sets IRQ_STAT[n]. If a set and a W1C clear land in the same cycle, set wins.
- Overflow: ch_ovf[n]=1 sets sticky ovf[n]. ovf[n] clears on the commit edge of a CH_STAT[n] read. If ch_ovf arrives in that same cycle, set wins.
- irq is combinational from registers (no input-to-output path).
- Reset: FSM=IDLE; bus_rdy=0; bus_rdat=0; ch_ctrl=CTRL_INIT per channel; ch_ctrl_wr=0; IRQ_STAT=0; IRQ_EN=0; SCRATCH=0; ovf=0; evt history=0; irq=0. Reset asserted mid-access aborts the access with no side effects.
- Elaboration error if NUM_CH>15, CNT_W>24, or 4+2*NUM_CH > 2^(AW-2).

Decomposition:
- csr_bank_pkg holds:
  - word offsets ADDR_ID, ADDR_IRQ_STAT, ADDR_IRQ_EN, ADDR_SCRATCH, ADDR_CH_BASE
  - ERR_BIT=15
  - FSM enum state_t {IDLE, ACK}
  - ch_stat_t struct
  - byte-lane merge function
- One sub-module, csr_bank_irq: edge detect, IRQ_STAT set/W1C priority, enable masking, irq output.

Test Plan:
- Reset, then read ID → rdy exactly 1 cycle after vld; rdat=32'h0002_0000; all outputs at their reset values.
- Write SCRATCH=32'hDEAD_BEEF with we=4'b0101 over prior 0 → read returns 32'h00AD_00EF.
- ch_busy[2]=1, write CH_CTRL[2]=32'h1234 → ch_ctrl unchanged, no pulse. Drop busy and rewrite → ch_ctrl[2]=32'h1234, ch_ctrl_wr[2] 1-cycle pulse.
- IRQ_EN=0x2, rising edge on ch_evt[1] → irq=1. Write IRQ_STAT=0x2 with a new edge in the same cycle → bit stays set. Repeat the W1C alone → irq=0.
- Pulse ch_ovf[0], read CH_STAT[0] → bit30=1; second read → bit30=0; cnt field mirrors ch_cnt[0]=16'hABCD.
- Read word 0x3FF → rdat=0 and IRQ_STAT[15]=1. Assert arst_n low during ACK of a SCRATCH write → SCRATCH=0 and FSM=IDLE.
